pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage CPU. Resolves taken-branch flush
//  (PCsrc from EX), load-use stalls and multi-cycle MUL occupancy of EX.
//  Drives the PC, IF/ID, ID/EX and EX/MEM enables and bubbles, plus perf counters.
//  Replaces ad-hoc per-hazard enable logic; sits between the hazard sources and
//  the pipeline registers.
// PARAMETERS
//  REG_W       5   register-specifier width
//  MUL_CYCLES  4   EX cycles a MUL occupies (>=2)
//  CNT_W       16  perf counter width
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  PCsrc        in   1      branch taken, resolved in EX
//  ex_memread   in   1      instruction in EX is a load
//  ex_rt        in   REG_W  load destination in EX
//  id_rs        in   REG_W  ID source 1
//  id_rt        in   REG_W  ID source 2
//  id_uses_rt   in   1      ID instruction reads rt
//  id_mul       in   1      ID instruction is a MUL
//  en_PC        out  1      PC write enable
//  en_IF        out  1      IF/ID write enable
//  flush_IF     out  1      clear IF/ID to NOP
//  en_EX        out  1      ID/EX write enable
//  bubble_EX    out  1      load NOP into ID/EX
//  bubble_MEM   out  1      load NOP into EX/MEM
//  mul_start    out  1      one-cycle pulse: MUL enters EX
//  pipe_ctl     out  3      {en_IF, flush_IF, en_PC}
//  stall_cycles out  CNT_W  cycles with en_PC=0, saturating
//  flush_count  out  CNT_W  taken branches, saturating
// BEHAVIOUR
//  States RUN, MUL_WAIT; down-counter mcnt. Outputs are combinational from state+inputs.
//  rst=1 (any state): next state RUN, mcnt=0, counters=0. Outputs while rst=1:
//   en_PC=0, en_IF=0, flush_IF=1, en_EX=1, bubble_EX=1, bubble_MEM=1, mul_start=0.
//  lu = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  RUN, priority PCsrc > lu > id_mul > normal:
//   PCsrc: en_PC=1, en_IF=1, flush_IF=1, bubble_EX=1, en_EX=1.
//     Stay RUN. flush_count++.
//   lu: en_PC=0, en_IF=0, en_EX=1, bubble_EX=1, flush_IF=0. Stay RUN.
//     Clears next cycle (load reaches MEM). Exactly one stall per hazard.
//   id_mul: all enables 1, no bubbles, mul_start=1.
//     Next MUL_WAIT, mcnt=MUL_CYCLES-2.
//   normal: en_PC=en_IF=en_EX=1, all flush/bubble=0.
//  MUL_WAIT: en_PC=en_IF=en_EX=0, bubble_MEM=1, other outputs 0.
//   mcnt==0 -> RUN, else mcnt--. Lasts MUL_CYCLES-1 cycles.
//   MUL then leaves EX on the first RUN cycle.
//   PCsrc/lu/id_mul ignored in MUL_WAIT. PCsrc=1 here is illegal; bench asserts.
//  Simultaneous PCsrc+lu or PCsrc+id_mul: branch wins, no stall, no mul_start.
//  lu+id_mul: stall first; MUL issues the following cycle.
//  stall_cycles++ every non-reset cycle with en_PC=0.
//  Both counters saturate at all-ones, no wrap.
//  rst during MUL_WAIT: abort. RUN next cycle, no residual mcnt.
// TESTING
//  Reset: rst=1 for 2 cycles -> pipe_ctl=3'b010, counters 0.
//   Release -> pipe_ctl=3'b101.
//  Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> 1 cycle en_PC=0, bubble_EX=1.
//   Then resumes; stall_cycles=1. Same with ex_rt=0 -> no stall.
//  Branch: PCsrc=1 one cycle -> pipe_ctl=3'b111, bubble_EX=1, flush_count=1.
//   PCsrc=1 with lu and id_mul also 1 -> same response, mul_start=0.
//  MUL: id_mul=1 -> mul_start pulse, then exactly 3 cycles en_PC=en_EX=0,
//   bubble_MEM=1, then RUN; stall_cycles=3.
//  lu+id_mul together -> 1 stall, then mul_start next cycle, then 3 wait cycles.
//  rst asserted on 2nd MUL_WAIT cycle -> RUN after reset, counters 0.
//   Saturation: preload/force 16'hFFFF, 2 stalls -> stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Central sequencer for the 5-stage pipeline: branch flush, load-use stall and
// multi-cycle MUL occupancy of EX, plus saturating stall/flush perf counters.
module pipeline_stall_ctrl #(
    parameter int REG_W      = 5,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCsrc,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_mul,
    output logic             en_PC,
    output logic             en_IF,
    output logic             flush_IF,
    output logic             en_EX,
    output logic             bubble_EX,
    output logic             bubble_MEM,
    output logic             mul_start,
    output logic [2:0]       pipe_ctl,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int MC_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MUL_WAIT = 1'b1;
    localparam logic [MC_W-1:0] MCNT_LOAD = MC_W'(MUL_CYCLES - 2);

    logic [0:0]      state, state_nxt;
    logic [MC_W-1:0] mcnt, mcnt_nxt;
    logic            lu;
    logic            flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign lu = ex_memread && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        en_PC      = 1'b1;
        en_IF      = 1'b1;
        flush_IF   = 1'b0;
        en_EX      = 1'b1;
        bubble_EX  = 1'b0;
        bubble_MEM = 1'b0;
        mul_start  = 1'b0;
        flush_inc  = 1'b0;
        state_nxt  = state;
        mcnt_nxt   = mcnt;
        if (rst) begin
            en_PC      = 1'b0;
            en_IF      = 1'b0;
            flush_IF   = 1'b1;
            bubble_EX  = 1'b1;
            bubble_MEM = 1'b1;
            state_nxt  = RUN;
            mcnt_nxt   = '0;
        end else if (state == MUL_WAIT) begin
            // EX is held by the MUL; hazard inputs are ignored until it drains
            en_PC      = 1'b0;
            en_IF      = 1'b0;
            en_EX      = 1'b0;
            bubble_MEM = 1'b1;
            if (mcnt == '0) begin
                state_nxt = RUN;
            end else begin
                mcnt_nxt = mcnt - 1'b1;
            end
        end else if (PCsrc) begin
            flush_IF  = 1'b1;
            bubble_EX = 1'b1;
            flush_inc = 1'b1;
        end else if (lu) begin
            // Single stall: the load moves to MEM and the hazard disappears
            en_PC     = 1'b0;
            en_IF     = 1'b0;
            bubble_EX = 1'b1;
        end else if (id_mul) begin
            mul_start = 1'b1;
            state_nxt = MUL_WAIT;
            mcnt_nxt  = MCNT_LOAD;
        end
    end

    assign pipe_ctl = {en_IF, flush_IF, en_PC};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            mcnt         <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
            if (!en_PC) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (flush_inc) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a cycle-level behavioural model
// feeds expectations into a queue that a negedge monitor drains and checks.
module tb_pipeline_stall_ctrl;

    localparam int MUL_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PCsrc = 1'b0, ex_memread = 1'b0, id_uses_rt = 1'b0, id_mul = 1'b0;
    logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;

    logic        en_PC, en_IF, flush_IF, en_EX, bubble_EX, bubble_MEM, mul_start;
    logic [2:0]  pipe_ctl;
    logic [15:0] stall_cycles, flush_count;

    logic        s_en_PC, s_en_IF, s_flush_IF, s_en_EX, s_bubble_EX, s_bubble_MEM, s_mul_start;
    logic [2:0]  s_pipe_ctl;
    logic [2:0]  s_stall_cycles, s_flush_count;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.REG_W(5), .MUL_CYCLES(MUL_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .PCsrc(PCsrc), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_mul(id_mul),
        .en_PC(en_PC), .en_IF(en_IF), .flush_IF(flush_IF), .en_EX(en_EX),
        .bubble_EX(bubble_EX), .bubble_MEM(bubble_MEM), .mul_start(mul_start),
        .pipe_ctl(pipe_ctl), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Narrow-counter copy so saturation is reached within a short run
    pipeline_stall_ctrl #(.REG_W(5), .MUL_CYCLES(MUL_CYCLES), .CNT_W(3)) sat_dut (
        .clk(clk), .rst(rst), .PCsrc(PCsrc), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_mul(id_mul),
        .en_PC(s_en_PC), .en_IF(s_en_IF), .flush_IF(s_flush_IF), .en_EX(s_en_EX),
        .bubble_EX(s_bubble_EX), .bubble_MEM(s_bubble_MEM), .mul_start(s_mul_start),
        .pipe_ctl(s_pipe_ctl), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    typedef struct {
        logic [9:0] ctl;
        int         stalls;
        int         flushes;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: raw event counts and remaining MUL wait cycles
    int m_wait = 0;
    int n_stall = 0;
    int n_flush = 0;

    function automatic logic [15:0] cap16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    function automatic logic [2:0] cap3(input int v);
        return (v > 7) ? 3'd7 : 3'(v);
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic pc, input logic mr, input logic [4:0] ert,
                         input logic [4:0] irs, input logic [4:0] irt, input logic ur,
                         input logic ml);
        exp_t       e;
        logic [6:0] b;  // {en_PC, en_IF, flush_IF, en_EX, bubble_EX, bubble_MEM, mul_start}
        logic       hz;
        @(posedge clk);
        #1;
        if (m_wait > 0) pc = 1'b0;
        rst = r; PCsrc = pc; ex_memread = mr; ex_rt = ert;
        id_rs = irs; id_rt = irt; id_uses_rt = ur; id_mul = ml;
        assert (!(m_wait > 0 && !r && PCsrc)) else $error("PCsrc driven during MUL wait");
        e.stalls  = n_stall;
        e.flushes = n_flush;
        if (r) begin
            b = 7'b0011110;
            m_wait = 0; n_stall = 0; n_flush = 0;
        end else if (m_wait > 0) begin
            b = 7'b0000010;
            m_wait--; n_stall++;
        end else begin
            hz = mr && ert != 0 && (ert == irs || (ur && ert == irt));
            if (pc) begin
                b = 7'b1111100; n_flush++;
            end else if (hz) begin
                b = 7'b0001100; n_stall++;
            end else if (ml) begin
                b = 7'b1101001; m_wait = MUL_CYCLES - 1;
            end else begin
                b = 7'b1101000;
            end
        end
        e.ctl = {b, b[5], b[4], b[6]};
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("ctl", 16'({en_PC, en_IF, flush_IF, en_EX, bubble_EX, bubble_MEM,
                              mul_start, pipe_ctl}), 16'(mon_e.ctl));
            check("small_ctl", 16'({s_en_PC, s_en_IF, s_flush_IF, s_en_EX, s_bubble_EX,
                                    s_bubble_MEM, s_mul_start, s_pipe_ctl}), 16'(mon_e.ctl));
            check("stall_cycles", stall_cycles, cap16(mon_e.stalls));
            check("flush_count", flush_count, cap16(mon_e.flushes));
            check("stall_cycles_sat", 16'(s_stall_cycles), 16'(cap3(mon_e.stalls)));
            check("flush_count_sat", 16'(s_flush_count), 16'(cap3(mon_e.flushes)));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        // Reset held two cycles, then release
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Load-use on rs, then no-stall with ex_rt = 0, then rt path
        drive(0, 0, 1, 5, 5, 1, 0, 0);
        idle(2);
        drive(0, 0, 1, 0, 0, 0, 1, 0);
        drive(0, 0, 1, 7, 1, 7, 1, 0);
        drive(0, 0, 1, 7, 1, 7, 0, 0);
        idle(1);
        // Branch alone, then branch with lu and MUL
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        drive(0, 1, 1, 5, 5, 0, 0, 1);
        idle(1);
        // MUL occupancy
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(5);
        // lu + MUL: stall, then MUL issues
        drive(0, 0, 1, 3, 3, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(5);
        // Reset on second MUL wait cycle
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Drive both narrow counters well past saturation
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 2, 2, 0, 0, 0);
            drive(0, 1, 0, 0, 0, 0, 0, 0);
        end
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(63) == 0, $urandom_range(5) == 0, $urandom_range(1) == 1,
                  5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  $urandom_range(1) == 1, $urandom_range(5) == 0);
        end
        idle(2);
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
